// File: rtl/uart_pkg.sv
// Shared UART receive-path constants: stored entry layout and default line terminator.
package uart_pkg;

   localparam int unsigned EntryW    = 10;
   localparam int unsigned DataW     = 8;
   localparam int unsigned ParityBit = 8;
   localparam int unsigned FrameBit  = 9;

   localparam logic [7:0] DefaultEol = 8'h0D;

   function automatic logic [EntryW-1:0] pack_entry(input logic [DataW-1:0] data,
                                                    input logic             par_err,
                                                    input logic             frm_err);
      return {frm_err, par_err, data};
   endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int unsigned AddrW = 4,
   parameter int unsigned Width = EntryW
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   // No reset: the owner masks the read data while the queue is empty.
   logic [Width-1:0] mem_q [2**AddrW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: stores bytes with their error flags, tracks
// buffered line terminators, and flags dropped bytes with a sticky overflow bit.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_W   = 4,
   parameter logic [7:0]  EOL_CHAR = DefaultEol
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_done_tick,
   input  logic [7:0]        din,
   input  logic              e_parity,
   input  logic              e_frame,
   input  logic              rd,
   output logic [7:0]        rd_data,
   output logic              rd_e_parity,
   output logic              rd_e_frame,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   input  logic              clr_overflow,
   output logic [ADDR_W:0]   line_count,
   output logic              line_ready
);

   localparam logic [ADDR_W:0] Depth  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   line_q, line_d;
   logic              overflow_q, overflow_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;

   logic              wr_en, rd_en, drop;
   logic              eol_in, eol_out;
   logic [EntryW-1:0] wr_entry, head;

   // A full FIFO can still accept a byte when the consumer frees a slot in the same cycle.
   assign wr_en   = rx_done_tick && (!full_q || rd);
   assign rd_en   = rd && !empty_q;
   assign drop    = rx_done_tick && full_q && !rd;
   assign eol_in  = (din == EOL_CHAR);
   assign eol_out = (head[DataW-1:0] == EOL_CHAR);

   assign wr_entry = pack_entry(din, e_parity, e_frame);

   uart_fifo_ram #(
      .AddrW (ADDR_W),
      .Width (EntryW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + PtrOne : rd_ptr_q;

      count_d = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase

      line_d = line_q;
      unique case ({wr_en && eol_in, rd_en && eol_out})
         2'b10:   line_d = line_q + CntOne;
         2'b01:   line_d = line_q - CntOne;
         default: line_d = line_q;
      endcase

      // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end

      full_d  = (count_d == Depth);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         line_q     <= '0;
         overflow_q <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         line_q     <= line_d;
         overflow_q <= overflow_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
      end
   end

   assign rd_data     = empty_q ? 8'h00 : head[DataW-1:0];
   assign rd_e_parity = empty_q ? 1'b0 : head[ParityBit];
   assign rd_e_frame  = empty_q ? 1'b0 : head[FrameBit];

   assign empty      = empty_q;
   assign full       = full_q;
   assign overflow   = overflow_q;
   assign line_count = line_q;
   assign line_ready = (line_q != '0);

endmodule
